// File: rtl/vq_pkg.sv
// Shared types, defaults and width helpers for the VQ codebook search block.
package vq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SCAN,
    DONE
  } vq_state_t;

  localparam int unsigned CW_NUM_DEF = 16;
  localparam int unsigned DIM_DEF    = 13;
  localparam int unsigned DATA_W_DEF = 14;

  // Ceiling log2, never below 1 so a derived index is at least one bit wide.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r++;
    return (r == 0) ? 1 : r;
  endfunction

  // Distance accumulator width: full square of a DATA_W+1 bit difference,
  // plus headroom for summing DIM of them.
  function automatic int unsigned acc_w(input int unsigned dim, input int unsigned data_w);
    return 2 * data_w + 2 + clog2(dim);
  endfunction

endpackage

// File: rtl/vq_codebook_search_if.sv
// Host/stream/result bus of the VQ codebook search block.
interface vq_codebook_search_if #(
  parameter int unsigned CW_NUM = vq_pkg::CW_NUM_DEF,
  parameter int unsigned DIM    = vq_pkg::DIM_DEF,
  parameter int unsigned DATA_W = vq_pkg::DATA_W_DEF
) ();

  localparam int unsigned IDX_W = vq_pkg::clog2(CW_NUM);
  localparam int unsigned DIM_W = vq_pkg::clog2(DIM);
  localparam int unsigned ACC_W = vq_pkg::acc_w(DIM, DATA_W);

  logic              wr_en;
  logic [IDX_W-1:0]  wr_cw;
  logic [DIM_W-1:0]  wr_dim;
  logic [DATA_W-1:0] wr_data;
  logic              wr_err;
  logic              rd_en;
  logic [IDX_W-1:0]  rd_cw;
  logic [DIM_W-1:0]  rd_dim;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              vec_valid;
  logic [DATA_W-1:0] vec_data;
  logic              vec_ready;
  logic              res_valid;
  logic              res_ready;
  logic [IDX_W-1:0]  res_idx;
  logic [ACC_W-1:0]  res_dist;
  logic              busy;

  modport master (
    output wr_en, wr_cw, wr_dim, wr_data, rd_en, rd_cw, rd_dim,
           vec_valid, vec_data, res_ready,
    input  wr_err, rd_data, rd_valid, vec_ready, res_valid, res_idx, res_dist, busy
  );

  modport slave (
    input  wr_en, wr_cw, wr_dim, wr_data, rd_en, rd_cw, rd_dim,
           vec_valid, vec_data, res_ready,
    output wr_err, rd_data, rd_valid, vec_ready, res_valid, res_idx, res_dist, busy
  );

endinterface

// File: rtl/vq_sdp_ram.sv
// Simple dual-port codebook RAM: one write port, one synchronous registered read port.
module vq_sdp_ram #(
  parameter int unsigned DEPTH  = 208,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 14
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              re,
  input  logic [ADDR_W-1:0] ra,
  output logic [DATA_W-1:0] rq
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Array write; contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  // Registered read; a same-address write in the same cycle yields the old word.
  always_ff @(posedge clk) begin
    if (re) rq <= mem[ra];
  end

endmodule

// File: rtl/vq_codebook_search.sv
// Codebook store plus nearest-codeword (squared Euclidean) search engine.
module vq_codebook_search
  import vq_pkg::*;
#(
  parameter int unsigned CW_NUM = CW_NUM_DEF,
  parameter int unsigned DIM    = DIM_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input logic                 clk,
  input logic                 rst_n,
  vq_codebook_search_if.slave bus
);

  localparam int unsigned IDX_W  = clog2(CW_NUM);
  localparam int unsigned DIM_W  = clog2(DIM);
  localparam int unsigned ACC_W  = acc_w(DIM, DATA_W);
  localparam int unsigned SQ_W   = 2 * DATA_W + 2;
  localparam int unsigned DEPTH  = CW_NUM * DIM;
  localparam int unsigned ADDR_W = clog2(DEPTH);

  vq_state_t state, state_nxt;

  logic              vec_hs, vec_last;
  logic [DIM_W-1:0]  ld_cnt;
  logic [DATA_W-1:0] vec_buf [DIM];

  logic [IDX_W-1:0]  cw_cnt;
  logic [DIM_W-1:0]  dim_cnt;
  logic              iss_done, s0_valid;
  logic [ADDR_W-1:0] eng_addr;

  logic              v1, first1, last1;
  logic [IDX_W-1:0]  cw1;
  logic [DIM_W-1:0]  dim1;
  logic              v2, first2, last2;
  logic [IDX_W-1:0]  cw2;
  logic [SQ_W-1:0]   sq2;

  logic signed [DATA_W:0] diff1;
  logic signed [SQ_W-1:0] diff_ext, sq_c;

  logic [ACC_W-1:0]  acc, acc_sum, best_dist;
  logic [IDX_W-1:0]  best_idx;
  logic              scan_end;

  logic              wr_in, rd_in, ram_we, ram_re, rd_acc, rd_zero;
  logic [ADDR_W-1:0] host_wa, host_ra, ram_ra;
  logic [DATA_W-1:0] ram_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, LOAD: if (vec_hs) state_nxt = vec_last ? SCAN : LOAD;
      SCAN:       if (scan_end) state_nxt = DONE;
      DONE:       if (bus.res_ready) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    bus.vec_ready = (state == IDLE) || (state == LOAD);
    bus.busy      = (state == SCAN) || (state == DONE);
    bus.res_valid = (state == DONE);
  end

  // Handshake, load-index and scan-control decodes.
  always_comb begin
    vec_hs   = bus.vec_valid && bus.vec_ready;
    vec_last = (ld_cnt == DIM_W'(DIM - 1));
    s0_valid = (state == SCAN) && !iss_done;
    eng_addr = ADDR_W'(32'(cw_cnt) * DIM + 32'(dim_cnt));
    scan_end = v2 && last2 && (cw2 == IDX_W'(CW_NUM - 1));
  end

  // Input vector buffer, filled coefficient 0 first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_cnt  <= '0;
      vec_buf <= '{default: '0};
    end else if (vec_hs) begin
      vec_buf[ld_cnt] <= bus.vec_data;
      ld_cnt          <= vec_last ? '0 : ld_cnt + DIM_W'(1);
    end
  end

  // Address issue: walks codeword-major, one element per cycle while in SCAN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cw_cnt   <= '0;
      dim_cnt  <= '0;
      iss_done <= 1'b0;
    end else if (state != SCAN) begin
      cw_cnt   <= '0;
      dim_cnt  <= '0;
      iss_done <= 1'b0;
    end else if (s0_valid) begin
      if (dim_cnt == DIM_W'(DIM - 1)) begin
        dim_cnt <= '0;
        if (cw_cnt == IDX_W'(CW_NUM - 1)) iss_done <= 1'b1;
        else                              cw_cnt   <= cw_cnt + IDX_W'(1);
      end else begin
        dim_cnt <= dim_cnt + DIM_W'(1);
      end
    end
  end

  // Difference and square of the element returned by the RAM this cycle.
  always_comb begin
    diff1    = $signed({vec_buf[dim1][DATA_W-1], vec_buf[dim1]}) - $signed({ram_q[DATA_W-1], ram_q});
    diff_ext = {{(SQ_W - DATA_W - 1){diff1[DATA_W]}}, diff1};
    sq_c     = diff_ext * diff_ext;
    acc_sum  = (first2 ? '0 : acc) + ACC_W'(sq2);
  end

  // Pipeline tags and squared-difference register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0; first1 <= 1'b0; last1 <= 1'b0; cw1 <= '0; dim1 <= '0;
      v2 <= 1'b0; first2 <= 1'b0; last2 <= 1'b0; cw2 <= '0; sq2  <= '0;
    end else begin
      v1     <= s0_valid;
      first1 <= (dim_cnt == '0);
      last1  <= (dim_cnt == DIM_W'(DIM - 1));
      cw1    <= cw_cnt;
      dim1   <= dim_cnt;
      v2     <= v1;
      first2 <= first1;
      last2  <= last1;
      cw2    <= cw1;
      sq2    <= sq_c;
    end
  end

  // Per-codeword accumulation and strict-less best tracking (ties keep lowest index).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      best_dist <= '0;
      best_idx  <= '0;
    end else if (v2) begin
      acc <= acc_sum;
      if (last2 && ((cw2 == '0) || (acc_sum < best_dist))) begin
        best_dist <= acc_sum;
        best_idx  <= cw2;
      end
    end
  end

  // Host port decodes; the engine owns the read port during SCAN.
  always_comb begin
    wr_in   = (32'(bus.wr_cw) < CW_NUM) && (32'(bus.wr_dim) < DIM);
    rd_in   = (32'(bus.rd_cw) < CW_NUM) && (32'(bus.rd_dim) < DIM);
    host_wa = ADDR_W'(32'(bus.wr_cw) * DIM + 32'(bus.wr_dim));
    host_ra = ADDR_W'(32'(bus.rd_cw) * DIM + 32'(bus.rd_dim));
    ram_we  = bus.wr_en && (state != SCAN) && wr_in;
    rd_acc  = bus.rd_en && (state != SCAN);
    ram_re  = (rd_acc && rd_in) || s0_valid;
    ram_ra  = (state == SCAN) ? eng_addr : host_ra;
  end

  // Host read-valid, out-of-range flag and dropped-write pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rd_valid <= 1'b0;
      rd_zero      <= 1'b0;
      bus.wr_err   <= 1'b0;
    end else begin
      bus.rd_valid <= rd_acc;
      rd_zero      <= !rd_in;
      bus.wr_err   <= bus.wr_en && (state == SCAN);
    end
  end

  // Result and read-data outputs; rd_data is forced to zero unless a valid in-range read.
  always_comb begin
    bus.res_idx  = best_idx;
    bus.res_dist = best_dist;
    bus.rd_data  = (bus.rd_valid && !rd_zero) ? ram_q : '0;
  end

  vq_sdp_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk (clk),
    .we  (ram_we),
    .wa  (host_wa),
    .wd  (bus.wr_data),
    .re  (ram_re),
    .ra  (ram_ra),
    .rq  (ram_q)
  );

endmodule

// File: tb/tb_vq_codebook_search.sv
// Directed self-checking bench for vq_codebook_search.
module tb_vq_codebook_search;
  import vq_pkg::*;

  localparam int unsigned CW_NUM = 16;
  localparam int unsigned DIM    = 13;
  localparam int unsigned DATA_W = 14;
  localparam int unsigned IDX_W  = clog2(CW_NUM);
  localparam int unsigned DIM_W  = clog2(DIM);
  // Last element in cycle t, res_valid in cycle t+211: that cycle starts
  // CW_NUM*DIM+2 = 210 rising edges after the edge that closes cycle t.
  localparam int LAT_EDGES = CW_NUM * DIM + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vq_codebook_search_if #(.CW_NUM(CW_NUM), .DIM(DIM), .DATA_W(DATA_W)) bus ();

  vq_codebook_search #(.CW_NUM(CW_NUM), .DIM(DIM), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int cw, input int dim, input int val);
    bus.wr_en   = 1'b1;
    bus.wr_cw   = IDX_W'(cw);
    bus.wr_dim  = DIM_W'(dim);
    bus.wr_data = DATA_W'(val);
    step();
    bus.wr_en   = 1'b0;
  endtask

  task automatic load_cw(input int cw, input int val);
    for (int d = 0; d < int'(DIM); d++) wr(cw, d, val);
  endtask

  task automatic rd_chk(input string tag, input int cw, input int dim, input int val);
    logic [DATA_W-1:0] e;
    e = DATA_W'(val);
    bus.rd_en  = 1'b1;
    bus.rd_cw  = IDX_W'(cw);
    bus.rd_dim = DIM_W'(dim);
    step();
    bus.rd_en  = 1'b0;
    chk({tag, "_valid"}, 64'(bus.rd_valid), 64'd1);
    chk(tag, 64'(bus.rd_data), 64'(e));
    step();
    chk({tag, "_vdrop"}, 64'(bus.rd_valid), 64'd0);
  endtask

  task automatic send_vec(input int val);
    for (int i = 0; i < int'(DIM); i++) begin
      bus.vec_valid = 1'b1;
      bus.vec_data  = DATA_W'(val);
      step();
    end
    bus.vec_valid = 1'b0;
  endtask

  task automatic wait_res(inout int n);
    while (!bus.res_valid && n < 2000) begin
      step();
      n++;
    end
  endtask

  task automatic finish_res(input string tag);
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    chk({tag, "_rv_drop"}, 64'(bus.res_valid), 64'd0);
    chk({tag, "_vrdy_back"}, 64'(bus.vec_ready), 64'd1);
  endtask

  task automatic run_vec(input string tag, input int val, input int exp_idx, input logic [63:0] exp_dist);
    int n;
    n = 0;
    send_vec(val);
    wait_res(n);
    chk({tag, "_lat"}, 64'(n), 64'(LAT_EDGES));
    chk({tag, "_idx"}, 64'(bus.res_idx), 64'(exp_idx));
    chk({tag, "_dist"}, 64'(bus.res_dist), exp_dist);
    finish_res(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    bus.wr_en = 1'b0; bus.wr_cw = '0; bus.wr_dim = '0; bus.wr_data = '0;
    bus.rd_en = 1'b0; bus.rd_cw = '0; bus.rd_dim = '0;
    bus.vec_valid = 1'b0; bus.vec_data = '0; bus.res_ready = 1'b0;

    #2;
    chk("rst_rd_data",   64'(bus.rd_data),   64'd0);
    chk("rst_rd_valid",  64'(bus.rd_valid),  64'd0);
    chk("rst_wr_err",    64'(bus.wr_err),    64'd0);
    chk("rst_vec_ready", 64'(bus.vec_ready), 64'd1);
    chk("rst_res_valid", 64'(bus.res_valid), 64'd0);
    chk("rst_res_idx",   64'(bus.res_idx),   64'd0);
    chk("rst_res_dist",  64'(bus.res_dist),  64'd0);
    chk("rst_busy",      64'(bus.busy),      64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // Codeword k holds 100*k in every coefficient.
    for (int k = 0; k < int'(CW_NUM); k++) load_cw(k, 100 * k);
    rd_chk("rd_5_7", 5, 7, 500);
    rd_chk("rd_15_12", 15, 12, 1500);
    rd_chk("rd_0_0", 0, 0, 0);
    // dim 13 would alias to cw3/dim0 (300) if not masked.
    rd_chk("rd_oor_dim", 2, 13, 0);

    // Same-cycle write and read of one address returns the old word.
    bus.wr_en = 1'b1; bus.wr_cw = 4'd6; bus.wr_dim = 4'd2; bus.wr_data = 14'd1234;
    bus.rd_en = 1'b1; bus.rd_cw = 4'd6; bus.rd_dim = 4'd2;
    step();
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    chk("wr_rd_collide_old", 64'(bus.rd_data), 64'd600);
    rd_chk("wr_rd_collide_new", 6, 2, 1234);
    wr(6, 2, 600);
    // cw1/dim14 would alias to cw2/dim1 if not ignored.
    wr(1, 14, 999);
    rd_chk("wr_oor_ignored", 2, 1, 200);

    // Vector all 300 -> cw3 exact match; a write during SCAN is dropped.
    n = 0;
    send_vec(300);
    chk("scan_busy", 64'(bus.busy), 64'd1);
    chk("scan_vec_ready", 64'(bus.vec_ready), 64'd0);
    bus.wr_en = 1'b1; bus.wr_cw = 4'd3; bus.wr_dim = 4'd0; bus.wr_data = 14'd7777;
    step();
    n++;
    bus.wr_en = 1'b0;
    chk("wr_err_pulse", 64'(bus.wr_err), 64'd1);
    step();
    n++;
    chk("wr_err_single", 64'(bus.wr_err), 64'd0);
    wait_res(n);
    chk("exact_lat", 64'(n), 64'(LAT_EDGES));
    chk("exact_idx", 64'(bus.res_idx), 64'd3);
    chk("exact_dist", 64'(bus.res_dist), 64'd0);

    // Result held while the consumer stalls.
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_valid", 64'(bus.res_valid), 64'd1);
      chk("hold_idx", 64'(bus.res_idx), 64'd3);
      chk("hold_dist", 64'(bus.res_dist), 64'd0);
      chk("hold_vec_ready", 64'(bus.vec_ready), 64'd0);
    end
    finish_res("exact");
    chk("idle_busy", 64'(bus.busy), 64'd0);
    rd_chk("scan_wr_dropped", 3, 0, 300);

    // Reset in the middle of a scan (cw2 is the best so far at this point).
    send_vec(300);
    repeat (50) step();
    rst_n = 1'b0;
    #1;
    chk("midrst_res_valid", 64'(bus.res_valid), 64'd0);
    chk("midrst_vec_ready", 64'(bus.vec_ready), 64'd1);
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_res_idx", 64'(bus.res_idx), 64'd0);
    chk("midrst_res_dist", 64'(bus.res_dist), 64'd0);
    step();
    rst_n = 1'b1;
    repeat (220) step();
    chk("midrst_no_result", 64'(bus.res_valid), 64'd0);
    rd_chk("midrst_cb_intact", 5, 7, 500);
    // 1490 vs cw15 (1500): 13 * 10^2.
    run_vec("fresh", 1490, 15, 64'd1300);

    // cw2 and cw4 equidistant from 300: 13 * 100^2, lower index wins.
    for (int k = 0; k < int'(CW_NUM); k++) load_cw(k, (k == 2) ? 200 : (k == 4) ? 400 : 2000);
    run_vec("tie", 300, 2, 64'd130000);

    // Full-scale: 13 * 16383^2, all codewords tied.
    for (int k = 0; k < int'(CW_NUM); k++) load_cw(k, -8192);
    run_vec("fullscale", 8191, 0, 64'd3489234957);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
